// File: rtl/rom_burst_arbiter_if.sv
// Bundles the requester, read-stream and rom signals of rom_burst_arbiter.
// Latency: none (wiring only).
// Backpressure: carried by rd_ready_i; requests are held until granted.
interface rom_burst_arbiter_if #(
    parameter int Width = 8,
    parameter int Depth = 5
);
    logic [1:0]       req_i;
    logic [Depth-1:0] req0_addr_i;
    logic [Depth-1:0] req0_len_i;
    logic             req0_scr_i;
    logic [Depth-1:0] req1_addr_i;
    logic [Depth-1:0] req1_len_i;
    logic             req1_scr_i;
    logic [1:0]       gnt_o;
    logic             busy_o;
    logic [Width-1:0] rd_data_o;
    logic             rd_valid_o;
    logic             rd_ready_i;
    logic             rd_id_o;
    logic             rd_last_o;
    logic             rom_cs_no;
    logic             rom_oe_o;
    logic [Depth-1:0] rom_addr_o;
    logic [Width-1:0] rom_data_i;

    modport slave (
        input  req_i, req0_addr_i, req0_len_i, req0_scr_i,
        input  req1_addr_i, req1_len_i, req1_scr_i, rd_ready_i, rom_data_i,
        output gnt_o, busy_o, rd_data_o, rd_valid_o, rd_id_o, rd_last_o,
        output rom_cs_no, rom_oe_o, rom_addr_o
    );

    modport master (
        output req_i, req0_addr_i, req0_len_i, req0_scr_i,
        output req1_addr_i, req1_len_i, req1_scr_i, rd_ready_i, rom_data_i,
        input  gnt_o, busy_o, rd_data_o, rd_valid_o, rd_id_o, rd_last_o,
        input  rom_cs_no, rom_oe_o, rom_addr_o
    );
endinterface

// File: rtl/rom_burst_arbiter.sv
// Round-robin burst reader for a shared async rom, one word per cycle on a registered stream.
// Latency: grant 1 cycle after request, first word 2 cycles after request.
// Backpressure: rd_ready_i low freezes rom address and output register; nothing dropped.
module rom_burst_arbiter #(
    parameter int Width = 8,
    parameter int Depth = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rom_burst_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [Depth-1:0] cur_addr;
    logic [Depth-1:0] remaining;
    logic             scr;
    logic             cur_id;
    logic             last_id;
    logic             grant_vld;
    logic             grant_id;
    logic             load;
    logic             last_word;
    logic [Width-1:0] scr_dat;

    generate
        if (Width == 8) begin : g_scr
            assign scr_dat = {bus.rom_data_i[0], bus.rom_data_i[7], bus.rom_data_i[1], bus.rom_data_i[6],
                              bus.rom_data_i[2], bus.rom_data_i[5], bus.rom_data_i[3], bus.rom_data_i[4]};
        end else begin : g_noscr
            assign scr_dat = bus.rom_data_i;
        end
    endgenerate

    always_comb begin
        // On contention the requester that did not win last time goes next.
        grant_vld      = |bus.req_i;
        grant_id       = (bus.req_i == 2'b11) ? ~last_id : bus.req_i[1];
        load           = ~bus.rd_valid_o | bus.rd_ready_i;
        last_word      = (remaining == '0);
        state_d        = state_q;
        bus.busy_o     = (state_q != IDLE);
        bus.rom_cs_no  = 1'b1;
        bus.rom_oe_o   = 1'b0;
        bus.rom_addr_o = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) state_d = READ;
            end
            READ: begin
                bus.rom_cs_no  = 1'b0;
                bus.rom_oe_o   = 1'b1;
                bus.rom_addr_o = cur_addr;
                if (load && last_word) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.rd_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_addr       <= '0;
            remaining      <= '0;
            scr            <= 1'b0;
            cur_id         <= 1'b0;
            last_id        <= 1'b1;
            bus.gnt_o      <= 2'b00;
            bus.rd_data_o  <= '0;
            bus.rd_valid_o <= 1'b0;
            bus.rd_id_o    <= 1'b0;
            bus.rd_last_o  <= 1'b0;
        end else begin
            bus.gnt_o <= 2'b00;
            unique case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        cur_addr  <= grant_id ? bus.req1_addr_i : bus.req0_addr_i;
                        remaining <= grant_id ? bus.req1_len_i  : bus.req0_len_i;
                        scr       <= grant_id ? bus.req1_scr_i  : bus.req0_scr_i;
                        cur_id    <= grant_id;
                        last_id   <= grant_id;
                        bus.gnt_o <= grant_id ? 2'b10 : 2'b01;
                    end
                end
                READ: begin
                    if (load) begin
                        bus.rd_data_o  <= scr ? scr_dat : bus.rom_data_i;
                        bus.rd_valid_o <= 1'b1;
                        bus.rd_id_o    <= cur_id;
                        bus.rd_last_o  <= last_word;
                        if (!last_word) begin
                            cur_addr  <= cur_addr + Depth'(1);
                            remaining <= remaining - Depth'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (bus.rd_ready_i) begin
                        bus.rd_valid_o <= 1'b0;
                        bus.rd_last_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Randomized bench for rom_burst_arbiter against a queue-based burst/round-robin model.
// Latency and backpressure are checked cycle by cycle through gnt_o, busy_o and the stream.
module tb_rom_burst_arbiter;
    localparam int W = 8;
    localparam int D = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_burst_arbiter_if #(.Width(W), .Depth(D)) bus ();
    rom_burst_arbiter #(.Width(W), .Depth(D)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    logic [W-1:0] rom [32];
    assign bus.rom_data_i = rom[bus.rom_addr_o];

    typedef struct packed {
        logic [7:0] dat;
        logic       id;
        logic       last;
    } word_t;

    word_t      exp_q[$];
    int         n_chk = 0;
    int         n_err = 0;
    logic       free;
    logic       last_gnt;
    logic [1:0] exp_gnt;
    logic [1:0] pend;
    logic [4:0] p_addr [2];
    logic [4:0] p_len  [2];
    logic       p_scr  [2];
    int         ready_pct;
    bit         force_q[$];
    logic [4:0] addr_log[$];
    logic [1:0] gnt_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output bit (7-k) takes input bit src[k].
    function automatic logic [7:0] scramble(input logic [7:0] d);
        int         src[8] = '{0, 7, 1, 6, 2, 5, 3, 4};
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[7-k] = d[src[k]];
        return r;
    endfunction

    task automatic post(input int i, input logic [4:0] a, input logic [4:0] l, input logic s);
        pend[i]   = 1'b1;
        p_addr[i] = a;
        p_len[i]  = l;
        p_scr[i]  = s;
    endtask

    task automatic drive();
        bus.req_i       = pend;
        bus.req0_addr_i = p_addr[0];
        bus.req0_len_i  = p_len[0];
        bus.req0_scr_i  = p_scr[0];
        bus.req1_addr_i = p_addr[1];
        bus.req1_len_i  = p_len[1];
        bus.req1_scr_i  = p_scr[1];
    endtask

    task automatic model_reset();
        exp_q.delete();
        free     = 1'b1;
        last_gnt = 1'b1;
        exp_gnt  = 2'b00;
        pend     = 2'b00;
    endtask

    task automatic cycle();
        int    w;
        word_t e;
        @(negedge clk);
        check("gnt", 32'(bus.gnt_o), 32'(exp_gnt));
        check("busy", 32'(bus.busy_o), 32'(!free));
        if (bus.gnt_o != 2'b00) gnt_log.push_back(bus.gnt_o);
        if (bus.rom_cs_no == 1'b0) addr_log.push_back(bus.rom_addr_o);
        for (int i = 0; i < 2; i++) begin
            if (bus.gnt_o[i]) begin
                pend[i]   = 1'b0;
                p_addr[i] = 5'($urandom);
                p_len[i]  = 5'($urandom);
                p_scr[i]  = 1'($urandom);
            end
        end
        if (force_q.size() != 0) bus.rd_ready_i = force_q.pop_front();
        else                     bus.rd_ready_i = ($urandom_range(0, 99) < ready_pct);
        drive();
        exp_gnt = 2'b00;
        if (free && pend != 2'b00) begin
            w        = (pend == 2'b11) ? int'(!last_gnt) : int'(pend[1]);
            last_gnt = w[0];
            free     = 1'b0;
            exp_gnt  = 2'(1 << w);
            for (int k = 0; k <= int'(p_len[w]); k++) begin
                e.dat  = rom[(int'(p_addr[w]) + k) % 32];
                if (p_scr[w]) e.dat = scramble(e.dat);
                e.id   = w[0];
                e.last = (k == int'(p_len[w]));
                exp_q.push_back(e);
            end
        end
        if (bus.rd_valid_o && bus.rd_ready_i) begin
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rd_data", 32'(bus.rd_data_o), 32'(e.dat));
                check("rd_id", 32'(bus.rd_id_o), 32'(e.id));
                check("rd_last", 32'(bus.rd_last_o), 32'(e.last));
                if (e.last) free = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        pend           = 2'b00;
        bus.rd_ready_i = 1'b0;
        drive();
        @(negedge clk);
        check("rst_gnt", 32'(bus.gnt_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_valid", 32'(bus.rd_valid_o), 32'd0);
        check("rst_data", 32'(bus.rd_data_o), 32'd0);
        check("rst_id", 32'(bus.rd_id_o), 32'd0);
        check("rst_last", 32'(bus.rd_last_o), 32'd0);
        check("rst_cs_n", 32'(bus.rom_cs_no), 32'd1);
        check("rst_oe", 32'(bus.rom_oe_o), 32'd0);
        check("rst_addr", 32'(bus.rom_addr_o), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        int t = 0;
        ready_pct = 100;
        while ((!free || exp_q.size() != 0 || pend != 2'b00) && t < 300) begin
            cycle();
            t++;
        end
        check("drain_in_time", 32'(t < 300), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        rom[5'h04] = 8'h58; rom[5'h05] = 8'hED; rom[5'h06] = 8'hB7; rom[5'h07] = 8'h34;
        rom[5'h08] = 8'hC9; rom[5'h09] = 8'h8F; rom[5'h0A] = 8'hA0; rom[5'h0B] = 8'h9B;
        rom[5'h10] = 8'hDA;
        for (int i = 0; i < 2; i++) begin
            p_addr[i] = '0;
            p_len[i]  = '0;
            p_scr[i]  = 1'b0;
        end
        ready_pct = 100;
        model_reset();
        do_reset();

        // Plain 4-word burst from requester 0.
        addr_log.delete();
        post(0, 5'h04, 5'd3, 1'b0);
        drain();
        check("t1_addr_cnt", 32'(addr_log.size()), 32'd4);

        // Single scrambled word from requester 1.
        post(1, 5'h10, 5'd0, 1'b1);
        drain();
        check("t2_cs_idle", 32'(bus.rom_cs_no), 32'd1);

        // Address wrap past the top of the rom.
        addr_log.delete();
        post(0, 5'h1F, 5'd5, 1'b0);
        drain();
        check("wrap_cnt", 32'(addr_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < addr_log.size(); k++)
            check("wrap_addr", 32'(addr_log[k]), 32'((31 + k) % 32));

        // Consumer stalls for three cycles after the first word.
        post(0, 5'h08, 5'd3, 1'b0);
        force_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        cycle();
        cycle();
        repeat (3) begin
            cycle();
            check("bp_valid", 32'(bus.rd_valid_o), 32'd1);
            check("bp_hold_dat", 32'(bus.rd_data_o), 32'h0C9);
            check("bp_hold_addr", 32'(bus.rom_addr_o), 32'h09);
        end
        drain();

        // Both requesters always pending: grants alternate starting with 0.
        do_reset();
        gnt_log.delete();
        post(0, 5'h00, 5'd0, 1'b0);
        post(1, 5'h01, 5'd0, 1'b0);
        t = 0;
        while (gnt_log.size() < 4 && t < 100) begin
            cycle();
            t++;
            if (gnt_log.size() < 3) begin
                if (!pend[0]) post(0, 5'h02, 5'd0, 1'b0);
                if (!pend[1]) post(1, 5'h03, 5'd0, 1'b0);
            end
        end
        check("rr_cnt", 32'(gnt_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < gnt_log.size(); k++)
            check("rr_gnt", 32'(gnt_log[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
        drain();

        // Reset while the second word of a 4-word burst is on the output.
        post(1, 5'h00, 5'd3, 1'b0);
        repeat (4) cycle();
        check("mid_valid", 32'(bus.rd_valid_o), 32'd1);
        do_reset();
        gnt_log.delete();
        post(0, 5'h05, 5'd0, 1'b0);
        post(1, 5'h06, 5'd0, 1'b0);
        t = 0;
        while (gnt_log.size() < 1 && t < 20) begin
            cycle();
            t++;
        end
        check("post_rst_gnt", (gnt_log.size() != 0) ? 32'(gnt_log[0]) : 32'd0, 32'd1);
        drain();

        // Random traffic with random backpressure.
        ready_pct = 70;
        repeat (3000) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0)
                    post(i, 5'($urandom),
                         ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
                         1'($urandom));
            end
            cycle();
        end
        drain();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
